ext_irq_controller: RTL

EXT_IRQ_CONTROLLER -- requirements
Module: ext_irq_controller

---
 rtl/irq_pkg.sv | 24 ++
 rtl/ext_irq_controller_if.sv | 53 +++++
 rtl/irq_sync_edge.sv | 38 +++
 rtl/ext_irq_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//
// Shared definitions for the external interrupt controller:
//   - NSRC_DEFAULT        : default number of external interrupt sources
//   - ACK_TIMEOUT_DEFAULT : default cycles ExtIRQ may wait for ExtIAck
//   - irq_state_e         : handshake FSM state encoding
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int NSRC_DEFAULT        = 8;
    localparam int ACK_TIMEOUT_DEFAULT = 1024;

    // Four-phase handshake with the processor:
    //   IDLE    - waiting for an enabled pending source
    //   ASSERT  - ExtIRQ high, waiting for ExtIAck
    //   RELEASE - ExtIRQ low, waiting for ExtIAck to drop
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } irq_state_e;

endpackage : irq_pkg

// File: rtl/ext_irq_controller_if.sv
// -----------------------------------------------------------------------------
// ext_irq_controller_if
//
// Bundles the interrupt request/acknowledge signals between the interrupt
// sources plus processor (master side) and the controller (slave side).
//
//   irq_src     : raw asynchronous request lines, rising edge = request
//   irq_mask    : 1 = source enabled for presentation
//   ExtIAck     : processor acknowledge (four-phase)
//   ExtIRQ      : registered interrupt request to the processor
//   irq_id      : index of the presented source, stable while ExtIRQ=1
//   irq_pending : registered pending bits (masked and unmasked)
//   irq_timeout : sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
interface ext_irq_controller_if
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT
) ();

    localparam int IDW = $clog2(NSRC);

    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] irq_mask;
    logic            ExtIAck;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] irq_pending;
    logic            irq_timeout;

    // Sources and processor side
    modport master (
        output irq_src,
        output irq_mask,
        output ExtIAck,
        input  ExtIRQ,
        input  irq_id,
        input  irq_pending,
        input  irq_timeout
    );

    // Controller side
    modport slave (
        input  irq_src,
        input  irq_mask,
        input  ExtIAck,
        output ExtIRQ,
        output irq_id,
        output irq_pending,
        output irq_timeout
    );

endinterface : ext_irq_controller_if

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
//
// One interrupt line: 2-flop synchronizer followed by a rising-edge detector.
//
//   clk   : sole clock
//   rst_n : asynchronous active-low reset, clears every flop
//   src   : raw asynchronous request line
//   rise  : one-cycle pulse when the synchronized line goes 0 -> 1
// -----------------------------------------------------------------------------
module irq_sync_edge
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= src;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

endmodule : irq_sync_edge

// File: rtl/ext_irq_controller.sv
// -----------------------------------------------------------------------------
// ext_irq_controller
//
// Collects edge-triggered requests from NSRC external sources into pending
// bits and presents the lowest-indexed enabled one to the processor using a
// four-phase ExtIRQ/ExtIAck handshake. A sticky flag reports a request that
// stayed unacknowledged for ACK_TIMEOUT cycles.
//
// Parameters:
//   NSRC        : number of sources, 2..32
//   ACK_TIMEOUT : cycles in ASSERT without ack before irq_timeout is set
//
// Ports:
//   CLOCK_50 : sole clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : ext_irq_controller_if.slave (requests, mask, handshake, status)
// -----------------------------------------------------------------------------
module ext_irq_controller
    import irq_pkg::*;
#(
    parameter int NSRC        = NSRC_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ext_irq_controller_if.slave  bus
);

    localparam int IDW  = $clog2(NSRC);
    localparam int CNTW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ASSERT  = ST_ASSERT;
    localparam logic [1:0] S_RELEASE = ST_RELEASE;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(ACK_TIMEOUT);
    localparam logic [NSRC-1:0] ONE_HOT0 = {{(NSRC-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Per-source synchronizer and edge detector
    // -------------------------------------------------------------------------
    logic [NSRC-1:0] rise;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            irq_sync_edge u_sync_edge (
                .clk   (CLOCK_50),
                .rst_n (reset),
                .src   (bus.irq_src[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Post-reset arming. The edge flops all clear to 0 in reset, so a line that
    // is already high would look like a fresh rising edge once it reaches
    // sync2. Edges are ignored until sync1, sync2 and prev have all been
    // refilled from the live input (three edges after release).
    // -------------------------------------------------------------------------
    logic [1:0] arm_reg;
    logic       edge_en;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            arm_reg <= 2'd0;
        end else if (arm_reg != 2'd3) begin
            arm_reg <= arm_reg + 2'd1;
        end
    end

    assign edge_en = (arm_reg == 2'd3);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]      state_reg,   state_next;
    logic [IDW-1:0]  id_reg,      id_next;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [CNTW-1:0] cnt_reg,     cnt_next;
    logic            irq_reg,     irq_next;
    logic            timeout_reg, timeout_next;

    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] req;
    logic [IDW-1:0]  sel_id;
    logic            ack_taken;

    assign set_vec   = rise & {NSRC{edge_en}};
    assign req       = pending_reg & bus.irq_mask;
    assign ack_taken = (state_reg == S_ASSERT) && bus.ExtIAck;

    // Clearing the serviced bit happens on the ack edge; a new edge on the
    // same source in that cycle must win, so set is OR-ed in after the clear.
    assign clr_vec      = ack_taken ? (ONE_HOT0 << id_reg) : '0;
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM and acknowledge timeout counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        cnt_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    state_next = S_ASSERT;
                    id_next    = sel_id;
                end
            end
            S_ASSERT: begin
                // id and the request are frozen here regardless of mask or
                // new higher-priority arrivals until the processor acks.
                if (bus.ExtIAck) begin
                    state_next = S_RELEASE;
                end else if (cnt_reg == CNT_MAX) begin
                    cnt_next = cnt_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!bus.ExtIAck) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The counter only reaches CNT_MAX while waiting in ASSERT without ack.
    assign timeout_next = timeout_reg | (cnt_next == CNT_MAX);
    assign irq_next     = (state_next == S_ASSERT);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            id_reg      <= '0;
            pending_reg <= '0;
            cnt_reg     <= '0;
            irq_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            irq_reg     <= irq_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.ExtIRQ      = irq_reg;
    assign bus.irq_id      = id_reg;
    assign bus.irq_pending = pending_reg;
    assign bus.irq_timeout = timeout_reg;

endmodule : ext_irq_controller
